// File: rtl/univ_shift_reg.sv
// Universal shift register: load, shift, rotate, arithmetic shift and clear with
// serial in/out, plus a burst engine that runs a counted sequence of shifts.
//
// state   | meaning
// S_IDLE  | single-step on enable; start requests a burst
// S_BURST | one step of the latched mode per edge until the count is exhausted
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] pin,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CW-1:0]    count,
    output logic [WIDTH-1:0] pout,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        M_HOLD  = 3'b000,
        M_LOAD  = 3'b001,
        M_SHL   = 3'b010,
        M_SHR   = 3'b011,
        M_ROTL  = 3'b100,
        M_ROTR  = 3'b101,
        M_ASR   = 3'b110,
        M_CLEAR = 3'b111
    } mode_e;

    typedef enum logic {S_IDLE, S_BURST} state_e;

    state_e           state_q;
    mode_e            mode_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sout_q, sout_d;
    logic             busy_q, done_q;
    mode_e            op;
    logic             burst_ok;

    // In BURST the latched mode drives the datapath; live mode is ignored.
    always_comb begin
        op       = (state_q == S_BURST) ? mode_q : mode_e'(mode);
        data_d   = data_q;
        sout_d   = sout_q;
        burst_ok = (count != '0) &&
                   (mode_e'(mode) inside {M_SHL, M_SHR, M_ROTL, M_ROTR, M_ASR});
        case (op)
            M_LOAD:  data_d = pin;
            M_SHL:   begin data_d = {data_q[WIDTH-2:0], sin_r};        sout_d = data_q[WIDTH-1]; end
            M_SHR:   begin data_d = {sin_l, data_q[WIDTH-1:1]};        sout_d = data_q[0];       end
            M_ROTL:  begin data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]}; sout_d = data_q[WIDTH-1]; end
            M_ROTR:  begin data_d = {data_q[0], data_q[WIDTH-1:1]};    sout_d = data_q[0];       end
            M_ASR:   begin data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]}; sout_d = data_q[0];    end
            M_CLEAR: data_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= M_HOLD;
            cnt_q   <= '0;
            data_q  <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (burst_ok) begin
                            state_q <= S_BURST;
                            busy_q  <= 1'b1;
                            mode_q  <= mode_e'(mode);
                            cnt_q   <= count;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end else if (enable) begin
                        data_q <= data_d;
                        sout_q <= sout_d;
                    end
                end
                S_BURST: begin
                    data_q <= data_d;
                    sout_q <= sout_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pout = data_q;
    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: arithmetic reference model compared every cycle,
// plus literal expectations on the directed scenarios.
module tb_univ_shift_reg;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [2:0]    mode;
    logic [W-1:0]  pin;
    logic          sin_l, sin_r, start;
    logic [CW-1:0] count;
    logic [W-1:0]  pout;
    logic          sout, busy, done;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .pin(pin),
        .sin_l(sin_l), .sin_r(sin_r), .start(start), .count(count),
        .pout(pout), .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [W-1:0] m_pout;
    logic         m_sout, m_busy, m_done;
    int           m_rem;
    logic [2:0]   m_mode;

    task automatic apply(input logic [2:0] md);
        logic [W-1:0] p;
        p = m_pout;
        case (md)
            3'd1: m_pout = pin;
            3'd2: begin m_pout = (p << 1) | W'(sin_r);             m_sout = p[W-1]; end
            3'd3: begin m_pout = (p >> 1) | (W'(sin_l) << (W-1));  m_sout = p[0];   end
            3'd4: begin m_pout = (p << 1) | (p >> (W-1));          m_sout = p[W-1]; end
            3'd5: begin m_pout = (p >> 1) | (p << (W-1));          m_sout = p[0];   end
            3'd6: begin m_pout = W'($signed(p) >>> 1);             m_sout = p[0];   end
            3'd7: m_pout = '0;
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pout = '0; m_sout = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            m_rem = 0; m_mode = 3'd0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                apply(m_mode);
                m_rem = m_rem - 1;
                if (m_rem == 0) begin m_busy = 1'b0; m_done = 1'b1; end
            end else if (start) begin
                if (count != 0 && mode >= 3'd2 && mode <= 3'd6) begin
                    m_busy = 1'b1; m_rem = int'(count); m_mode = mode;
                end else begin
                    m_done = 1'b1;
                end
            end else if (enable) begin
                apply(mode);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp += 4;
            if (pout !== m_pout) begin n_bad++; $display("FAIL model_pout t=%0t got %h want %h", $time, pout, m_pout); end
            if (sout !== m_sout) begin n_bad++; $display("FAIL model_sout t=%0t got %b want %b", $time, sout, m_sout); end
            if (busy !== m_busy) begin n_bad++; $display("FAIL model_busy t=%0t got %b want %b", $time, busy, m_busy); end
            if (done !== m_done) begin n_bad++; $display("FAIL model_done t=%0t got %b want %b", $time, done, m_done); end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic step(input logic [2:0] md, input logic [W-1:0] d, input logic sl, input logic sr);
        mode = md; pin = d; sin_l = sl; sin_r = sr; enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    task automatic burst(input logic [2:0] md, input logic [CW-1:0] n);
        mode = md; count = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; mode = 3'd0; pin = '0;
        sin_l = 1'b0; sin_r = 1'b0; start = 1'b0; count = '0;
        #12;
        check("rst_pout", 32'(pout), 32'h0);
        check("rst_busy_done", {30'd0, busy, done}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // load and hold
        step(3'd1, 8'hA5, 0, 0);  check("load", 32'(pout), 32'hA5);
        mode = 3'd1; pin = 8'h3C; tick();
        check("hold_en0", 32'(pout), 32'hA5);

        // single steps from A5
        step(3'd2, 8'h00, 0, 1);  check("shl", 32'(pout), 32'h4B); check("shl_sout", 32'(sout), 32'h1);
        step(3'd1, 8'hA5, 0, 0);
        step(3'd3, 8'h00, 0, 0);  check("shr", 32'(pout), 32'h52); check("shr_sout", 32'(sout), 32'h1);
        step(3'd1, 8'hA5, 0, 0);
        step(3'd6, 8'h00, 0, 0);  check("asr", 32'(pout), 32'hD2);
        step(3'd1, 8'hA5, 0, 0);
        step(3'd4, 8'h00, 0, 0);  check("rotl", 32'(pout), 32'h4B);
        step(3'd1, 8'hA5, 0, 0);
        step(3'd5, 8'h00, 0, 0);  check("rotr", 32'(pout), 32'hD2); check("rotr_sout", 32'(sout), 32'h1);
        step(3'd7, 8'h00, 0, 0);  check("clear", 32'(pout), 32'h0); check("clear_sout", 32'(sout), 32'h1);

        // burst ROTL x3 from 81
        step(3'd1, 8'h81, 0, 0);
        burst(3'd4, 4'd3);        check("b_e0", {23'd0, busy, pout}, {23'd0, 1'b1, 8'h81});
        tick();                   check("b_e1", 32'(pout), 32'h03);
        tick();                   check("b_e2", 32'(pout), 32'h06);
        tick();                   check("b_e3", {22'd0, busy, done, pout}, {22'd0, 2'b01, 8'h0C});
        check("b_sout", 32'(sout), 32'h0);
        tick();                   check("b_e4_done", 32'(done), 32'h0);

        // collisions during a burst
        step(3'd1, 8'h81, 0, 0);
        burst(3'd4, 4'd3);
        tick();
        start = 1'b1; enable = 1'b1; mode = 3'd1; pin = 8'hFF; count = 4'd1;
        tick();
        start = 1'b0; enable = 1'b0;
        tick();                   check("coll_result", {22'd0, busy, done, pout}, {22'd0, 2'b01, 8'h0C});
        tick();

        // start and enable together while idle
        pin = 8'hFF; enable = 1'b1; sin_r = 1'b0;
        burst(3'd2, 4'd2);
        enable = 1'b0;
        check("se_e0", {23'd0, busy, pout}, {23'd0, 1'b1, 8'h0C});
        tick(); tick();           check("se_done", {22'd0, busy, done, pout}, {22'd0, 2'b01, 8'h30});
        tick();

        // degenerate bursts
        burst(3'd2, 4'd0);        check("cnt0", {22'd0, busy, done, pout}, {22'd0, 2'b01, 8'h30});
        tick();                   check("cnt0_e1", {22'd0, busy, done}, 32'h0);
        pin = 8'hAA;
        burst(3'd1, 4'd4);        check("load_burst", {22'd0, busy, done, pout}, {22'd0, 2'b01, 8'h30});
        tick();                   check("load_burst_e1", {22'd0, busy, done}, 32'h0);

        // count beyond WIDTH fills with serial data
        sin_l = 1'b1;
        burst(3'd3, 4'd9);
        repeat (9) tick();
        check("long_shr", {22'd0, busy, done, pout}, {22'd0, 2'b01, 8'hFF});
        sin_l = 1'b0;
        tick();

        // ASR burst keeps sign
        step(3'd1, 8'h90, 0, 0);
        burst(3'd6, 4'd3);
        repeat (3) tick();        check("asr_burst", 32'(pout), 32'hF2);
        tick();

        // async reset mid-burst
        step(3'd1, 8'h5A, 0, 0);
        burst(3'd5, 4'd5);
        #1 rst_n = 1'b0;
        #1;
        check("arst_pout", 32'(pout), 32'h0);
        check("arst_flags", {29'd0, sout, busy, done}, 32'h0);
        tick(); #1 rst_n = 1'b1;
        tick(); tick();           check("arst_idle", {23'd0, busy, pout}, 32'h0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
